// File: rtl/input_replay_pkg.sv
// rtl/input_replay_pkg.sv - shared state encoding, button indices and entry width for input_replay
package input_replay_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RECORD     = 2'd1;
  localparam logic [1:0] ST_PLAY_FETCH = 2'd2;
  localparam logic [1:0] ST_PLAY_RUN   = 2'd3;

  localparam int LEFT_BTN  = 0;
  localparam int RIGHT_BTN = 1;
  localparam int JUMP_BTN  = 2;

  // A stored entry is {button levels, run length in ticks}
  function automatic int entry_width(input int btn_num, input int run_width);
    return btn_num + run_width;
  endfunction

endpackage

// File: rtl/input_replay_ram.sv
// rtl/input_replay_ram.sv - single-port run-length buffer, synchronous write, registered read
module replay_ram #(
  parameter int WIDTH      = 15,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/input_replay.sv
// rtl/input_replay.sv - records button levels as run-length entries and replays them as button levels
module input_replay
  import input_replay_pkg::*;
#(
  parameter int BTN_NUM    = 3,
  parameter int RUN_WIDTH  = 12,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int TICK_N     = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [BTN_NUM-1:0]    btn_in,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  stop,
  output logic [BTN_NUM-1:0]    btn_out,
  output logic                  recording,
  output logic                  playing,
  output logic                  mem_full,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  play_done
);

  localparam int ENTRY_W = entry_width(BTN_NUM, RUN_WIDTH);
  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam int TICK_W  = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

  logic [1:0]           r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [BTN_NUM-1:0]   r_run_state;
  logic [RUN_WIDTH-1:0] r_run_cnt;
  logic [RUN_WIDTH-1:0] r_remain;
  logic [PTR_W-1:0]     r_entry_count;
  logic                 r_mem_full;
  logic                 r_play_done;
  logic [BTN_NUM-1:0]   r_btn_out;
  logic                 r_fetch_wait;

  logic                  w_tick;
  logic                  w_tick_clr;
  logic                  w_pending;
  logic                  w_room;
  logic                  w_extend;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ENTRY_W-1:0]    w_wdata;
  logic [ENTRY_W-1:0]    w_rdata;
  logic [PTR_W-1:0]      w_rd_next;

  assign w_tick     = (r_tick_cnt == TICK_W'(TICK_N - 1));
  assign w_tick_clr = (r_state == ST_IDLE) &&
                      (rec_start || (play_start && (r_entry_count != '0)));

  assign w_pending = (r_run_cnt != '0);
  assign w_room    = (r_wr_ptr < PTR_W'(DEPTH));
  assign w_extend  = (btn_in == r_run_state) && (r_run_cnt != RUN_MAX);
  assign w_rd_next = r_rd_ptr + 1'b1;

  // A stop flushes the pending run; a tick flushes it when the level changes or the run saturates
  assign w_we = (r_state == ST_RECORD) && w_pending && w_room &&
                (stop || (w_tick && !w_extend));

  assign w_addr  = (r_state == ST_RECORD) ? r_wr_ptr[ADDR_WIDTH-1:0] : r_rd_ptr[ADDR_WIDTH-1:0];
  assign w_wdata = {r_run_state, r_run_cnt};

  replay_ram #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (sys_clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_tick_clr || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_run_state   <= '0;
      r_run_cnt     <= '0;
      r_remain      <= '0;
      r_entry_count <= '0;
      r_mem_full    <= 1'b0;
      r_play_done   <= 1'b0;
      r_btn_out     <= '0;
      r_fetch_wait  <= 1'b0;
    end else begin
      r_play_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_btn_out <= btn_in;
          if (rec_start) begin
            r_state       <= ST_RECORD;
            r_wr_ptr      <= '0;
            r_run_cnt     <= '0;
            r_mem_full    <= 1'b0;
            r_entry_count <= '0;
          end else if (play_start) begin
            if (r_entry_count == '0) begin
              r_play_done <= 1'b1;
            end else begin
              r_rd_ptr     <= '0;
              r_fetch_wait <= 1'b0;
              r_state      <= ST_PLAY_FETCH;
            end
          end
        end

        ST_RECORD: begin
          r_btn_out <= btn_in;
          if (stop) begin
            r_entry_count <= w_we ? (r_wr_ptr + 1'b1) : r_wr_ptr;
            r_state       <= ST_IDLE;
          end else if (w_tick) begin
            if (!w_pending) begin
              r_run_state <= btn_in;
              r_run_cnt   <= RUN_WIDTH'(1);
            end else if (w_extend) begin
              r_run_cnt <= r_run_cnt + 1'b1;
            end else if (!w_room) begin
              r_mem_full    <= 1'b1;
              r_entry_count <= PTR_W'(DEPTH);
              r_state       <= ST_IDLE;
            end else begin
              r_wr_ptr    <= r_wr_ptr + 1'b1;
              r_run_state <= btn_in;
              r_run_cnt   <= RUN_WIDTH'(1);
            end
          end
        end

        // First cycle presents the address, second cycle latches the registered read data
        ST_PLAY_FETCH: begin
          if (stop) begin
            r_btn_out   <= '0;
            r_play_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_fetch_wait <= 1'b0;
            r_btn_out    <= w_rdata[ENTRY_W-1 -: BTN_NUM];
            r_remain     <= w_rdata[RUN_WIDTH-1:0];
            r_state      <= ST_PLAY_RUN;
          end
        end

        ST_PLAY_RUN: begin
          if (stop) begin
            r_btn_out   <= '0;
            r_play_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_tick) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == RUN_WIDTH'(1)) begin
              r_rd_ptr <= w_rd_next;
              if (w_rd_next == r_entry_count) begin
                r_btn_out   <= '0;
                r_play_done <= 1'b1;
                r_state     <= ST_IDLE;
              end else begin
                r_fetch_wait <= 1'b0;
                r_state      <= ST_PLAY_FETCH;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign btn_out     = r_btn_out;
  assign recording   = (r_state == ST_RECORD);
  assign playing     = (r_state == ST_PLAY_FETCH) || (r_state == ST_PLAY_RUN);
  assign mem_full    = r_mem_full;
  assign entry_count = r_entry_count;
  assign play_done   = r_play_done;

endmodule

// File: tb/tb_input_replay.sv
// tb/tb_input_replay.sv - scoreboard bench for input_replay record, replay, saturation, full and abort paths
module tb_input_replay;
  import input_replay_pkg::*;

  localparam logic [2:0] B_NONE  = 3'b000;
  localparam logic [2:0] B_LEFT  = 3'(1 << LEFT_BTN);
  localparam logic [2:0] B_RIGHT = 3'(1 << RIGHT_BTN);
  localparam logic [2:0] B_JUMP  = 3'(1 << JUMP_BTN);

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] btn_in;
  logic       rec_start, play_start, stop;
  logic [2:0] btn_out;
  logic       recording, playing, mem_full, play_done;
  logic [2:0] entry_count;

  always #5 sys_clk = ~sys_clk;

  input_replay #(
    .BTN_NUM(3), .RUN_WIDTH(3), .DEPTH(4), .ADDR_WIDTH(2), .TICK_N(4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .btn_in      (btn_in),
    .rec_start   (rec_start),
    .play_start  (play_start),
    .stop        (stop),
    .btn_out     (btn_out),
    .recording   (recording),
    .playing     (playing),
    .mem_full    (mem_full),
    .entry_count (entry_count),
    .play_done   (play_done)
  );

  typedef struct {
    logic [2:0] btn;
    logic       pd;
    int         gap;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur;
  int         checks = 0;
  int         errors = 0;
  logic       mon_on = 1'b0;
  logic [2:0] prev_btn = 3'b000;
  int         gap = 0;

  // Monitor: every change of btn_out or play_done pulse is an output event
  always @(negedge sys_clk) begin
    gap = gap + 1;
    if (btn_out !== prev_btn || play_done === 1'b1) begin
      if (mon_on) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_event btn_out=%b play_done=%b gap=%0d", btn_out, play_done, gap);
        end else begin
          cur = exp_q.pop_front();
          if (btn_out !== cur.btn || play_done !== cur.pd || (cur.gap >= 0 && gap != cur.gap)) begin
            errors = errors + 1;
            $display("FAIL replay_event got btn_out=%b play_done=%b gap=%0d required btn_out=%b play_done=%b gap=%0d",
                     btn_out, play_done, gap, cur.btn, cur.pd, cur.gap);
          end
        end
      end
      gap = 0;
    end
    prev_btn = btn_out;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] b, input logic pd, input int g);
    ev_t e;
    e.btn = b;
    e.pd  = pd;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s pending_events got %0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1; step(1); rec_start = 1'b0;
  endtask

  task automatic pulse_play();
    play_start = 1'b1; step(1); play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; btn_in = B_NONE;
    rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    step(3);
    chk("reset_btn_out", btn_out, 0);
    chk("reset_recording", recording, 0);
    chk("reset_playing", playing, 0);
    chk("reset_mem_full", mem_full, 0);
    chk("reset_entry_count", entry_count, 0);
    chk("reset_play_done", play_done, 0);
    sys_rst = 1'b0;
    step(1);

    // Passthrough with one cycle of latency
    btn_in = B_LEFT | B_JUMP;
    chk("passthru_before_edge", btn_out, 0);
    step(1);
    chk("passthru_btn_out", btn_out, 3'b101);
    chk("passthru_recording", recording, 0);
    chk("passthru_playing", playing, 0);
    btn_in = B_NONE;
    step(2);

    // Simultaneous starts: record wins; stop before any tick stores nothing
    rec_start = 1'b1; play_start = 1'b1; step(1); rec_start = 1'b0; play_start = 1'b0;
    chk("prio_recording", recording, 1);
    chk("prio_playing", playing, 0);
    pulse_stop();
    chk("prio_stop_recording", recording, 0);
    chk("prio_entry_count", entry_count, 0);

    // Empty playback only pulses play_done
    mon_on = 1'b1;
    push(B_NONE, 1'b1, -1);
    pulse_play();
    chk("empty_play_playing", playing, 0);
    wait_drain("empty_play", 5);

    // Basic record: 001 for 3 ticks, 100 for 2 ticks
    mon_on = 1'b0;
    pulse_rec();
    btn_in = B_LEFT;  step(12);
    btn_in = B_JUMP;  step(8);
    pulse_stop();
    chk("basic_entry_count", entry_count, 2);
    chk("basic_recording", recording, 0);
    chk("basic_mem_full", mem_full, 0);
    btn_in = B_NONE;
    step(3);

    mon_on = 1'b1;
    push(B_LEFT, 1'b0, -1);
    push(B_JUMP, 1'b0, 12);
    push(B_NONE, 1'b1, 6);
    pulse_play();
    chk("basic_play_playing", playing, 1);
    wait_drain("basic_replay", 60);
    chk("basic_after_playing", playing, 0);

    // Saturation: 10 ticks of 010 becomes {010,7},{010,3}
    mon_on = 1'b0;
    pulse_rec();
    btn_in = B_RIGHT; step(40);
    pulse_stop();
    chk("sat_entry_count", entry_count, 2);
    btn_in = B_NONE;
    step(3);

    mon_on = 1'b1;
    push(B_RIGHT, 1'b0, -1);
    push(B_NONE, 1'b1, 38);
    pulse_play();
    wait_drain("sat_replay", 80);

    // Stop in the middle of playback
    push(B_RIGHT, 1'b0, -1);
    push(B_NONE, 1'b1, 8);
    pulse_play();
    step(9);
    pulse_stop();
    chk("abort_playing", playing, 0);
    wait_drain("abort_replay", 5);

    // Full: a new level on each of 6 ticks overflows a 4-entry buffer
    mon_on = 1'b0;
    pulse_rec();
    for (int k = 1; k <= 6; k++) begin
      btn_in = 3'(k);
      step(4);
      if (k == 5) begin
        chk("full_early_mem_full", mem_full, 0);
        chk("full_early_recording", recording, 1);
      end
    end
    chk("full_mem_full", mem_full, 1);
    chk("full_recording", recording, 0);
    chk("full_entry_count", entry_count, 4);
    btn_in = B_NONE;
    step(3);

    // Reset while in PLAY_RUN discards the recording
    mon_on = 1'b1;
    push(B_LEFT, 1'b0, -1);
    push(B_NONE, 1'b0, 1);
    pulse_play();
    step(2);
    chk("rst_run_playing", playing, 1);
    sys_rst = 1'b1;
    step(1);
    chk("rst_btn_out", btn_out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_recording", recording, 0);
    chk("rst_mem_full", mem_full, 0);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_play_done", play_done, 0);
    sys_rst = 1'b0;
    wait_drain("rst_abort", 3);

    push(B_NONE, 1'b1, -1);
    pulse_play();
    chk("rst_replay_playing", playing, 0);
    wait_drain("rst_replay", 5);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
